// File: rtl/hbc_mcp_pkg.sv
// Shared constants for the math co-processor host bus front end:
// register addresses, controller states and status-byte bit positions.
package hbc_mcp_pkg;

   localparam logic [2:0] ADDR_AH     = 3'd0;
   localparam logic [2:0] ADDR_AL     = 3'd1;
   localparam logic [2:0] ADDR_BH     = 3'd2;
   localparam logic [2:0] ADDR_BL     = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   localparam int STAT_BUSY    = 7;
   localparam int STAT_READY   = 6;
   localparam int STAT_OVERRUN = 5;

endpackage

// File: rtl/hbc_sync_edge.sv
// Multi-stage synchronizer for one asynchronous strobe, with a rising-edge
// detect on the synchronized level.
module hbc_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hbc_mcp_bus_if.sv
// Host bus front end: synchronizes WRn/RDn, assembles operands, sequences the
// math core and serves result/status read-back. IRQ output built only with HBC_MCP_IRQ_EN.
module hbc_mcp_bus_if
   import hbc_mcp_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [2:0] TRIG_ADDR   = ADDR_BL,
   parameter logic [4:0] STATUS_ID   = 5'h0A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WRn,
   input  logic        RDn,
   input  logic [2:0]  address,
   inout  wire  [7:0]  data,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic        start,
   input  logic [31:0] result,
   input  logic        done,
   output logic        irq
);

   logic                         wr_sync, wr_rise, rd_sync, rd_rise;
   logic [SYNC_STAGES-1:0][2:0]  addr_pipe_q, addr_pipe_d;
   logic [SYNC_STAGES-1:0][7:0]  data_pipe_q, data_pipe_d;
   logic [2:0]                   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [7:0]                   wr_data_q, wr_data_d;
   state_t                       state_q, state_d;
   logic [15:0]                  op_a_q, op_a_d, op_b_q, op_b_d;
   logic [31:0]                  hold_q, hold_d;
   logic                         ready_q, ready_d, overrun_q, overrun_d;
   logic                         start_q, start_d;
   logic                         busy, stat_clr;
   logic [7:0]                   status, rd_byte;

   hbc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_wr_sync (
      .clk(clk), .rst(rst), .async_in(WRn), .sync_out(wr_sync), .rise(wr_rise));

   hbc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rd_sync (
      .clk(clk), .rst(rst), .async_in(RDn), .sync_out(rd_sync), .rise(rd_rise));

   assign busy     = (state_q != IDLE);
   assign stat_clr = rd_rise && (rd_addr_q == ADDR_STATUS);

   always_comb begin
      addr_pipe_d = {addr_pipe_q[SYNC_STAGES-2:0], address};
      data_pipe_d = {data_pipe_q[SYNC_STAGES-2:0], data};
      // Track address/data while the synced strobe is low, so at its rising
      // edge these hold the values from the last low cycle.
      wr_addr_d   = wr_sync ? wr_addr_q : addr_pipe_q[SYNC_STAGES-1];
      wr_data_d   = wr_sync ? wr_data_q : data_pipe_q[SYNC_STAGES-1];
      rd_addr_d   = rd_sync ? rd_addr_q : addr_pipe_q[SYNC_STAGES-1];
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      hold_d      = hold_q;
      ready_d     = ready_q;
      overrun_d   = overrun_q;
      start_d     = (state_q == START);

      if (stat_clr) overrun_d = 1'b0;

      // A set from a dropped commit overrides a same-cycle status-read clear.
      if (wr_rise) begin
         if (busy) begin
            overrun_d = 1'b1;
         end else begin
            case (wr_addr_q)
               ADDR_AH: op_a_d[15:8] = wr_data_q;
               ADDR_AL: op_a_d[7:0]  = wr_data_q;
               ADDR_BH: op_b_d[15:8] = wr_data_q;
               ADDR_BL: op_b_d[7:0]  = wr_data_q;
               default: ;
            endcase
            if (wr_addr_q == TRIG_ADDR) state_d = START;
         end
      end

      case (state_q)
         START: begin
            ready_d = 1'b0;
            state_d = BUSY;
         end
         BUSY: begin
            if (done) begin
               hold_d  = result;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_pipe_q <= '0;
         data_pipe_q <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         hold_q      <= '0;
         ready_q     <= 1'b0;
         overrun_q   <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         addr_pipe_q <= addr_pipe_d;
         data_pipe_q <= data_pipe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_addr_q   <= rd_addr_d;
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         hold_q      <= hold_d;
         ready_q     <= ready_d;
         overrun_q   <= overrun_d;
         start_q     <= start_d;
      end
   end

`ifdef HBC_MCP_IRQ_EN
   logic latched_q, latched_d, irq_q, irq_d;

   always_comb begin
      latched_d = (state_q == BUSY) && done;
      irq_d     = irq_q;
      if (stat_clr)  irq_d = 1'b0;
      if (latched_q) irq_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         latched_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         latched_q <= latched_d;
         irq_q     <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   // Read-back uses the raw address so the host sees data within its strobe.
   always_comb begin
      status               = {3'b000, STATUS_ID};
      status[STAT_BUSY]    = busy;
      status[STAT_READY]   = ready_q;
      status[STAT_OVERRUN] = overrun_q;
      rd_byte              = 8'h00;
      case (address)
         3'd0:        rd_byte = hold_q[31:24];
         3'd1:        rd_byte = hold_q[23:16];
         3'd2:        rd_byte = hold_q[15:8];
         3'd3:        rd_byte = hold_q[7:0];
         ADDR_STATUS: rd_byte = status;
         default:     rd_byte = 8'h00;
      endcase
   end

   assign data  = RDn ? 8'hzz : rd_byte;
   assign op_a  = op_a_q;
   assign op_b  = op_b_q;
   assign start = start_q;

endmodule

// File: tb/tb_hbc_mcp_bus_if.sv
// Self-checking bench for hbc_mcp_bus_if: table-driven directed vectors,
// hand-written timing corners and random host traffic against a register-level model.
module tb_hbc_mcp_bus_if;

   localparam int SYNC = 2;
`ifdef HBC_MCP_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        WRn = 1'b1;
   logic        RDn = 1'b1;
   logic [2:0]  address = 3'd0;
   logic        done = 1'b0;
   logic [31:0] result = 32'h0;
   logic        host_oe = 1'b0;
   logic [7:0]  host_data = 8'h00;
   wire  [7:0]  data;
   logic [15:0] op_a, op_b;
   logic        start, irq;

   assign data = host_oe ? host_data : 8'hzz;

   hbc_mcp_bus_if #(.SYNC_STAGES(SYNC), .TRIG_ADDR(3'd3), .STATUS_ID(5'h0A)) dut (
      .clk(clk), .rst(rst), .WRn(WRn), .RDn(RDn), .address(address), .data(data),
      .op_a(op_a), .op_b(op_b), .start(start), .result(result), .done(done), .irq(irq));

   // clock / cycle counter / start monitor
   always #5 clk = ~clk;

   int cyc = 0, start_cnt = 0, start_cyc = 0, rise_cyc = 0;
   int n_vec = 0, n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (start) begin
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
   end

   // register-level reference model
   logic [15:0] m_a = 16'h0, m_b = 16'h0;
   logic [31:0] m_hold = 32'h0;
   bit          m_ready = 0, m_ovr = 0, m_busy = 0, m_irq = 0;

   function automatic logic [7:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return m_hold[31:24];
         3'd1: return m_hold[23:16];
         3'd2: return m_hold[15:8];
         3'd3: return m_hold[7:0];
         3'd4: return {m_busy, m_ready, m_ovr, 5'h0A};
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic exp_irq();
      return IRQ_EN ? m_irq : 1'b0;
   endfunction

   task automatic model_reset();
      m_a = 16'h0; m_b = 16'h0; m_hold = 32'h0;
      m_ready = 0; m_ovr = 0; m_busy = 0; m_irq = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic wr_ex(input logic [2:0] a, input logic [7:0] d0, input logic [7:0] d,
                        input int low, input bit ds);
      @(posedge clk); #1;
      address = a; host_data = d0; host_oe = 1'b1; WRn = 1'b0;
      repeat (low - 1) @(posedge clk);
      #1 host_data = d;
      @(posedge clk); #1;
      WRn = 1'b1; rise_cyc = cyc;
      repeat (SYNC + 1) @(posedge clk);
      #1 if (ds) done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      @(posedge clk); #1;
      host_oe = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] v);
      @(posedge clk); #1;
      address = a; host_oe = 1'b0; RDn = 1'b0;
      #2 v = data;
      repeat (2) @(posedge clk);
      #1 RDn = 1'b1;
      repeat (SYNC + 3) @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d0, input logic [7:0] d,
                           input int low, input bit ds);
      int sc0;
      bit trig;
      sc0  = start_cnt;
      trig = 1'b0;
      if (m_busy) begin
         m_ovr = 1'b1;
      end else begin
         case (a)
            3'd0: m_a[15:8] = d;
            3'd1: m_a[7:0]  = d;
            3'd2: m_b[15:8] = d;
            3'd3: m_b[7:0]  = d;
            default: ;
         endcase
         if (a == 3'd3) begin
            trig = 1'b1; m_busy = 1'b1; m_ready = 1'b0;
         end
      end
      wr_ex(a, d0, d, low, ds);
      chk("start_count", start_cnt - sc0, {31'd0, trig});
      if (trig) chk("start_latency", start_cyc - rise_cyc, SYNC + 2);
      chk("op_a", {16'h0, op_a}, {16'h0, m_a});
      chk("op_b", {16'h0, op_b}, {16'h0, m_b});
      chk("irq_after_write", {31'd0, irq}, {31'd0, exp_irq()});
   endtask

   task automatic rd_effect(input logic [2:0] a);
      if (a == 3'd4) begin
         m_ovr = 1'b0; m_irq = 1'b0;
      end
   endtask

   task automatic do_read(input logic [2:0] a);
      logic [7:0] v;
      logic [7:0] e;
      e = m_read(a);
      rd(a, v);
      chk("read_data", {24'h0, v}, {24'h0, e});
      rd_effect(a);
      chk("irq_after_read", {31'd0, irq}, {31'd0, exp_irq()});
   endtask

   task automatic do_done(input logic [31:0] r);
      @(posedge clk); #1;
      result = r; done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      chk("irq_at_latch", {31'd0, irq}, {31'd0, exp_irq()});
      if (m_busy) begin
         m_hold = r; m_ready = 1'b1; m_busy = 1'b0; m_irq = 1'b1;
      end
      @(posedge clk); #1;
      chk("irq_after_latch", {31'd0, irq}, {31'd0, exp_irq()});
      @(posedge clk); #1;
   endtask

   typedef struct { logic [2:0] a; logic [7:0] d; logic [15:0] ea; logic [15:0] eb; } wvec_t;
   typedef struct { logic [2:0] a; logic [7:0] e; } rvec_t;
   wvec_t wtab[5];
   rvec_t rtab[8];
   logic [7:0] v;
   int k;

   initial begin
      wtab[0] = '{3'd0, 8'h12, 16'h1200, 16'h0000};
      wtab[1] = '{3'd1, 8'h34, 16'h1234, 16'h0000};
      wtab[2] = '{3'd5, 8'h77, 16'h1234, 16'h0000};
      wtab[3] = '{3'd2, 8'hFF, 16'h1234, 16'hFF00};
      wtab[4] = '{3'd3, 8'hFE, 16'h1234, 16'hFFFE};
      rtab[0] = '{3'd0, 8'hFF};
      rtab[1] = '{3'd1, 8'hFD};
      rtab[2] = '{3'd2, 8'hB9};
      rtab[3] = '{3'd3, 8'h98};
      rtab[4] = '{3'd5, 8'h00};
      rtab[5] = '{3'd6, 8'h00};
      rtab[6] = '{3'd7, 8'h00};
      rtab[7] = '{3'd4, 8'h4A};

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_op_a", {16'h0, op_a}, 32'h0);
      chk("reset_op_b", {16'h0, op_b}, 32'h0);
      chk("reset_start", {31'd0, start}, 32'h0);
      chk("reset_irq", {31'd0, irq}, 32'h0);
      for (int i = 0; i < 8; i++) do_read(i[2:0]);

      // operand writes and start, table-driven
      for (int i = 0; i < 5; i++) begin
         do_write(wtab[i].a, wtab[i].d, wtab[i].d, 2, 1'b0);
         chk("tab_op_a", {16'h0, op_a}, {16'h0, wtab[i].ea});
         chk("tab_op_b", {16'h0, op_b}, {16'h0, wtab[i].eb});
      end
      result = 32'h1357_9BDF;
      repeat (4) @(posedge clk);
      do_done(32'hFFFD_B998);
      for (int i = 0; i < 8; i++) begin
         rd(rtab[i].a, v);
         chk("tab_read", {24'h0, v}, {24'h0, rtab[i].e});
         rd_effect(rtab[i].a);
         chk("tab_irq", {31'd0, irq}, {31'd0, exp_irq()});
      end

      // overrun while busy, then recovery
      result = 32'hDEAD_BEEF;
      do_write(3'd3, 8'hFE, 8'hFE, 2, 1'b0);
      do_write(3'd0, 8'h55, 8'h55, 2, 1'b0);
      chk("overrun_op_a", {16'h0, op_a}, 32'h0000_1234);
      rd(3'd4, v);
      chk("overrun_status", {24'h0, v}, 32'h0000_00AA);
      rd_effect(3'd4);
      repeat (20) @(posedge clk);
      do_done(32'h0000_1111);
      do_read(3'd4);

      // bus released while RDn is high
      @(posedge clk); #1;
      address = 3'd4; host_data = 8'hC3; host_oe = 1'b1;
      #2 chk("bus_release", {24'h0, data}, 32'h0000_00C3);
      host_oe = 1'b0;

      // minimum strobe width with late data change
      do_write(3'd1, 8'hEE, 8'h5A, 2, 1'b0);
      chk("late_data_op_a", {16'h0, op_a}, 32'h0000_125A);

      // done arriving during START is ignored
      do_write(3'd3, 8'h01, 8'h02, 3, 1'b1);
      do_read(3'd4);

      // simultaneous dropped commit and status-read clear: set wins
      @(posedge clk); #1;
      address = 3'd4; host_oe = 1'b0; WRn = 1'b0; RDn = 1'b0;
      repeat (2) @(posedge clk);
      #1 WRn = 1'b1; RDn = 1'b1;
      repeat (SYNC + 3) @(posedge clk);
      #1;
      m_ovr = 1'b1; m_irq = 1'b0;
      do_read(3'd4);
      do_done(32'h8000_0001);
      for (int i = 0; i < 5; i++) do_read(i[2:0]);

      // reset mid-operation, then a stray done
      do_write(3'd3, 8'h77, 8'h77, 2, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      chk("midreset_irq", {31'd0, irq}, 32'h0);
      repeat (2) @(posedge clk);
      do_done(32'hCAFE_F00D);
      chk("midreset_op_a", {16'h0, op_a}, 32'h0);
      for (int i = 0; i < 5; i++) do_read(i[2:0]);

      // random host traffic
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         if (k < 5) begin
            if ($urandom_range(0, 3) == 0)
               do_write(3'd3, 8'($urandom), 8'($urandom), $urandom_range(2, 4), 1'b0);
            else
               do_write(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                        $urandom_range(2, 4), 1'b0);
         end else if (k < 8) begin
            do_read(3'($urandom_range(0, 7)));
         end else begin
            do_done($urandom);
         end
      end

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
